// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO group reader: state encoding and default geometry.
package fifo_reader_pkg;

  // Default number of words delivered per FIFO pop (power of two, >= 2).
  localparam int PAR_READ_DEFAULT    = 4;
  // Default width of one data word in bits.
  localparam int BUFFER_SIZE_DEFAULT = 16;

  // IDLE: no group held. SEND: a group is held and being serialised.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : fifo_reader_pkg

// File: rtl/fifo_reader_sel.sv
// Combinational word mux: picks word idx_i out of the held group.
module fifo_reader_sel
  import fifo_reader_pkg::*;
#(
  parameter int PAR_READ    = PAR_READ_DEFAULT,
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEFAULT
) (
  input  logic [PAR_READ*BUFFER_SIZE-1:0] hold_i,
  input  logic [$clog2(PAR_READ)-1:0]     idx_i,
  output logic [BUFFER_SIZE-1:0]          word_o
);

  localparam int IDX_W = $clog2(PAR_READ);

  // Select word idx_i; word k sits at bits [k*BUFFER_SIZE +: BUFFER_SIZE].
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    word_o = '0;
    for (int k = 0; k < PAR_READ; k++) begin
      if (idx_i == IDX_W'(k)) begin
        word_o = hold_i[k*BUFFER_SIZE +: BUFFER_SIZE];
      end
    end
  end

endmodule : fifo_reader_sel

// File: rtl/fifo_reader.sv
// Reads PAR_READ-word groups from a FIFO and streams them out one word per
// accepted handshake, prefetching the next group on the last word's acceptance.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int PAR_READ    = PAR_READ_DEFAULT,
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fifo_empty,
  input  logic                            fifo_read_en,
  input  logic [PAR_READ*BUFFER_SIZE-1:0] fifo_data,
  output logic                            fifo_pop,
  input  logic                            flush,
  output logic [BUFFER_SIZE-1:0]          out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy
);

  localparam int                IDX_W    = $clog2(PAR_READ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [PAR_READ*BUFFER_SIZE-1:0] hold_q, hold_d;
  logic [BUFFER_SIZE-1:0]          sel_word;

  logic pop_ok;
  logic accept;
  logic accept_last;
  logic is_send;

  assign is_send     = (state_q == SEND);
  assign pop_ok      = !fifo_empty && fifo_read_en && !flush && !rst;
  assign accept      = out_valid && out_ready;
  assign accept_last = accept && (idx_q == LAST_IDX);
  // A new group loads when nothing is held, or in the same cycle the last word leaves.
  assign fifo_pop    = pop_ok && (!is_send || accept_last);

  fifo_reader_sel #(
    .PAR_READ    (PAR_READ),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_sel (
    .hold_i (hold_q),
    .idx_i  (idx_q),
    .word_o (sel_word)
  );

  assign out_valid = is_send;
  assign out_last  = is_send && (idx_q == LAST_IDX);
  assign out_data  = is_send ? sel_word : '0;
  assign busy      = is_send;

  // Next-state logic: flush beats pop, pop beats accept, so a flush discards even an accepted word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      hold_d  = '0;
    end else if (fifo_pop) begin
      state_d = SEND;
      idx_d   = '0;
      hold_d  = fifo_data;
    end else if (accept_last) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (accept) begin
      idx_d   = idx_q + 1'b1;
    end
  end

  // State, index and hold registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the hold register is reset too, so a stale group can never reach out_data after reset.
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

endmodule : fifo_reader

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter PAR_READ, default 4: words delivered per FIFO pop; SHALL be a power of two and at least 2.
REQ-002 Parameter BUFFER_SIZE, default 16: width of one data word in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 fifo_empty  input  1  FIFO holds fewer than PAR_READ readable words.
REQ-006 fifo_read_en  input  1  FIFO permits a read this cycle.
REQ-007 fifo_data  input  PAR_READ*BUFFER_SIZE  FIFO read group; word k occupies bits [k*BUFFER_SIZE +: BUFFER_SIZE].
REQ-008 fifo_pop  output  1  advances the FIFO read pointer by PAR_READ; drives the FIFO count_read_pointer input.
REQ-009 flush  input  1  synchronous abort of the current group.
REQ-010 out_data  output  BUFFER_SIZE  current serial word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts the word.
REQ-013 out_last  output  1  out_data is word PAR_READ-1 of its group.
REQ-014 busy  output  1  high whenever the block is in state SEND.

Function
REQ-015 The FSM SHALL have two states, IDLE and SEND; a word index idx SHALL be clog2(PAR_READ) bits wide.
REQ-016 The signal pop_ok SHALL equal !fifo_empty && fifo_read_en && !flush && !rst.
REQ-017 fifo_pop SHALL be combinational and SHALL equal pop_ok && (state==IDLE || accept_last).
REQ-018 accept SHALL equal out_valid && out_ready; accept_last SHALL equal accept && idx==PAR_READ-1.
REQ-019 On each cycle with fifo_pop=1, fifo_data SHALL be captured into a hold register, idx SHALL clear to 0, and state SHALL become SEND.
REQ-020 In SEND: out_valid=1, out_data=hold word idx, out_last=(idx==PAR_READ-1); in IDLE: out_valid=0, out_last=0, out_data=0.
REQ-021 On accept with idx<PAR_READ-1, idx SHALL increment by 1.
REQ-022 On accept_last without fifo_pop, state SHALL return to IDLE.
REQ-023 On accept_last with fifo_pop, the next group SHALL load with no bubble cycle.
REQ-024 With out_valid=1 and out_ready=0, out_data, out_last and idx SHALL hold.
REQ-025 Latency SHALL be exactly one cycle from a pop in IDLE to the first out_valid.
REQ-026 flush=1 SHALL force IDLE next cycle, clear idx, discard the held group, and suppress fifo_pop; flush SHALL win over a simultaneous accept.
REQ-027 fifo_pop SHALL never assert while fifo_empty=1 or fifo_read_en=0.

Reset
REQ-028 While rst=1: fifo_pop=0; and on the next edge state=IDLE, idx=0, hold=0.
REQ-029 After that edge: out_valid=0, out_last=0, out_data=0, busy=0.
REQ-030 rst mid-group SHALL discard the remaining words with no further pop.

Structure
REQ-031 A shared package SHALL hold the IDLE/SEND state encoding and the default values of PAR_READ and BUFFER_SIZE.
REQ-032 One sub-module, fifo_reader_sel, SHALL implement the combinational word mux (hold register and idx in; word out).

Verification (PAR_READ=4, BUFFER_SIZE=16)
REQ-033 Apply rst, then hold fifo_empty=1 for 10 cycles -> fifo_pop=0, out_valid=0, busy=0 throughout.
REQ-034 Drive fifo_data=0x4444_3333_2222_1111, fifo_empty=0, fifo_read_en=1, out_ready=1 -> fifo_pop for 1 cycle; out_data shows 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; out_last=1 only with 0x4444.
REQ-035 Same group with out_ready=0 on the 2nd and 3rd valid cycles -> out_data holds 0x2222 for 3 cycles; the group completes in 6 cycles.
REQ-036 Two groups available back-to-back with out_ready=1 -> second pop coincides with acceptance of 0x4444; 8 words are delivered in 8 consecutive cycles.
REQ-037 flush asserted after 0x2222 is accepted -> out_valid=0 the next cycle; no fifo_pop; 0x3333 is never output.
REQ-038 fifo_empty=0 with fifo_read_en=0 -> fifo_pop=0 and out_valid stays 0.
